// File: rtl/ripple_carry_adder_pkg.sv
// Shared constants for the ripple-carry adder slice.
package ripple_carry_adder_pkg;

  localparam int ADDER_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/ripple_carry_adder_if.sv
// Operand/result bundle between the adder and whoever feeds it.
interface ripple_carry_adder_if
  import ripple_carry_adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH_DEFAULT
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c;
  logic             in_valid;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] carry;
  logic             out_valid;

  modport master (
    output a, b, c, in_valid,
    input  sum, carry, out_valid
  );

  modport slave (
    input  a, b, c, in_valid,
    output sum, carry, out_valid
  );

endinterface

// File: rtl/ripple_carry_adder_full_adder.sv
// One-bit full adder; one stage of the ripple chain.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic half_sum;

  assign half_sum = x ^ y;
  assign s        = half_sum ^ ci;
  assign co       = (x & y) | (ci & half_sum);

endmodule

// File: rtl/ripple_carry_adder.sv
// Registered ripple-carry adder: combinational full-adder chain, one-cycle latency,
// outputs hold their last result while no new operands arrive.
module ripple_carry_adder
  import ripple_carry_adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH_DEFAULT
) (
  input logic                clk,
  input logic                rst_n,
  ripple_carry_adder_if.slave bus
);

  logic [WIDTH-1:0] add_sum;
  logic [WIDTH-1:0] add_carry;

  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] carry_q;
  logic [WIDTH-1:0] carry_d;
  logic             valid_q;
  logic             valid_d;

  // Each stage keeps its own carry nets so the chain is not a self-referencing vector.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_stage
      logic ci_w;
      logic co_w;

      if (gi == 0) begin : g_first
        assign ci_w = bus.c;
      end else begin : g_rest
        assign ci_w = g_stage[gi-1].co_w;
      end

      full_adder u_fa (
        .x  (bus.a[gi]),
        .y  (bus.b[gi]),
        .ci (ci_w),
        .s  (add_sum[gi]),
        .co (co_w)
      );

      assign add_carry[gi] = co_w;
    end
  endgenerate

  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    valid_d = 1'b0;
    if (bus.in_valid) begin
      sum_d   = add_sum;
      carry_d = add_carry;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= '0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
    end
  end

  assign bus.sum       = sum_q;
  assign bus.carry     = carry_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Scoreboard bench: driver queues the expected outputs for each edge, monitor checks them.
module tb_ripple_carry_adder;

  typedef struct {
    logic       v;
    logic [3:0] s;
    logic [3:0] cy;
    string      name;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  ripple_carry_adder_if #(.WIDTH(4)) bus ();

  ripple_carry_adder #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of stimulus and record what the outputs must be after the next edge.
  task automatic drive(input logic rst_v, input logic [3:0] av, input logic [3:0] bv,
                       input logic cv, input logic vv, input logic ev,
                       input logic [3:0] es, input logic [3:0] ec, input string nm);
    exp_t e;
    @(negedge clk);
    rst_n        = rst_v;
    bus.a        = av;
    bus.b        = bv;
    bus.c        = cv;
    bus.in_valid = vv;
    e.v    = ev;
    e.s    = es;
    e.cy   = ec;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.out_valid !== e.v || bus.sum !== e.s || bus.carry !== e.cy) begin
          errors++;
          $display("FAIL %s: got valid=%b sum=%b carry=%b, want valid=%b sum=%b carry=%b",
                   e.name, bus.out_valid, bus.sum, bus.carry, e.v, e.s, e.cy);
        end else begin
          $display("ok   %s: valid=%b sum=%b carry=%b", e.name, bus.out_valid, bus.sum, bus.carry);
        end
      end else if (bus.out_valid === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got valid=1 sum=%b carry=%b, want no output",
                 bus.sum, bus.carry);
      end
    end
  end

  // Driver
  initial begin
    int tot;
    int msk;
    logic [3:0] es;
    logic [3:0] ec;
    int wait_cycles;

    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.c        = 1'b0;
    bus.in_valid = 1'b0;

    drive(1'b0, 4'd15, 4'd15, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, "reset_priority");
    drive(1'b0, 4'd15, 4'd15, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, "reset_hold");
    drive(1'b1, 4'd9,  4'd9,  1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, "idle_after_reset");
    drive(1'b1, 4'd1,  4'd5,  1'b0, 1'b1, 1'b1, 4'b0110, 4'b0001, "add_1_5_0");
    drive(1'b1, 4'd2,  4'd7,  1'b1, 1'b1, 1'b1, 4'b1010, 4'b0111, "add_2_7_1");
    drive(1'b1, 4'd3,  4'd5,  1'b1, 1'b1, 1'b1, 4'b1001, 4'b0111, "b2b_3_5_1");
    drive(1'b1, 4'd3,  4'd0,  1'b1, 1'b1, 1'b1, 4'b0100, 4'b0011, "add_3_0_1");
    drive(1'b1, 4'd6,  4'd2,  1'b0, 1'b0, 1'b0, 4'b0100, 4'b0011, "hold_1");
    drive(1'b1, 4'd6,  4'd2,  1'b0, 1'b0, 1'b0, 4'b0100, 4'b0011, "hold_2");
    drive(1'b1, 4'd15, 4'd1,  1'b0, 1'b1, 1'b1, 4'b0000, 4'b1111, "ovf_15_1_0");
    drive(1'b1, 4'd15, 4'd15, 1'b1, 1'b1, 1'b1, 4'b1111, 4'b1111, "ovf_15_15_1");
    drive(1'b0, 4'd7,  4'd7,  1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, "mid_reset");
    drive(1'b1, 4'd8,  4'd8,  1'b0, 1'b1, 1'b1, 4'b0000, 4'b1000, "first_after_reset");

    // Reference carries: carry-out of stage k is bit k+1 of the sum of the low k+1 bits.
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          tot = ai + bi + ci;
          es  = tot[3:0];
          for (int k = 0; k < 4; k++) begin
            msk   = (1 << (k + 1)) - 1;
            tot   = ((ai & msk) + (bi & msk) + ci) >> (k + 1);
            ec[k] = tot[0];
          end
          drive(1'b1, 4'(ai), 4'(bi), 1'(ci), 1'b1, 1'b1, es, ec,
                $sformatf("exh_%0d_%0d_%0d", ai, bi, ci));
        end
      end
    end

    // Last exhaustive vector is 15+15+1, so held outputs are 1111/1111.
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'b1111, 4'b1111, "final_hold");

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ripple_carry_adder.md
RIPPLE_CARRY_ADDER -- requirements
Module: ripple_carry_adder

Interface
REQ-001 Parameter: WIDTH, default 4, operand/result bit width (>=1).
REQ-002 Port: clk  input  1  rising-edge clock; all state updates on this edge.
REQ-003 Port: rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 Port: a  input  WIDTH  addend A, unsigned.
REQ-005 Port: b  input  WIDTH  addend B, unsigned.
REQ-006 Port: c  input  1  carry-in to stage 0.
REQ-007 Port: in_valid  input  1  qualifies a, b and c for capture.
REQ-008 Port: sum  output  WIDTH  registered sum bits, stage i drives sum[i].
REQ-009 Port: carry  output  WIDTH  registered per-stage carry-outs, carry[i] = carry-out of stage i; carry[WIDTH-1] = final carry-out.
REQ-010 Port: out_valid  output  1  high for one cycle when sum/carry hold a new result.

Function
REQ-011 Stage 0 SHALL compute s0 = a[0]^b[0]^c, co0 = a[0]&b[0] | c&(a[0]^b[0]).
REQ-012 Stage i>0 SHALL use carry-out of stage i-1 as its carry-in (ripple chain, no lookahead).
REQ-013 {carry[WIDTH-1], sum} SHALL equal a + b + c, modulo 2^(WIDTH+1), for every input combination.
REQ-014 Latency SHALL be exactly 1 clk: inputs sampled at edge N with in_valid=1 appear on sum/carry at edge N, out_valid=1 during cycle N..N+1.
REQ-015 When in_valid=0 at an edge, sum and carry SHALL hold previous values and out_valid SHALL be 0.
REQ-016 Back-to-back in_valid=1 SHALL produce one result per cycle, no bubbles, no throughput limit.
REQ-017 Overflow (a+b+c >= 2^WIDTH) SHALL set carry[WIDTH-1]=1 and sum to the low WIDTH bits; no saturation, no flag beyond carry.
REQ-018 Adder core SHALL be purely combinational between input sampling and output registers; no inferred latches.

Reset
REQ-019 When rst_n=0 at a rising clk edge, sum, carry and out_valid SHALL be 0 after that edge, regardless of in_valid.
REQ-020 Reset SHALL take priority over a simultaneous in_valid=1; the input in that cycle is discarded.
REQ-021 First result after reset release SHALL appear one cycle after the first edge with rst_n=1 and in_valid=1.

Structure
REQ-022 A shared package SHALL hold the default width constant (ADDER_WIDTH_DEFAULT = 4).
REQ-023 One sub-module full_adder (inputs x, y, ci; outputs s, co) SHALL be instantiated WIDTH times via generate to form the chain.
REQ-024 Output registers (sum, carry, out_valid) SHALL reside in ripple_carry_adder, not in full_adder.

Verification
REQ-025 Reset: rst_n=0 with a=4'd15, b=4'd15, c=1, in_valid=1 -> next edge sum=0000, carry=0000, out_valid=0.
REQ-026 a=1, b=5, c=0, in_valid=1 -> next edge sum=0110, carry=0001, out_valid=1.
REQ-027 a=2, b=7, c=1 -> sum=1010, carry=0111; then a=3, b=5, c=1 back-to-back -> sum=1001, carry=0111 one cycle later.
REQ-028 a=3, b=0, c=1 -> sum=0100, carry=0011; then in_valid=0 with a=6, b=2 -> outputs hold 0100/0011, out_valid=0.
REQ-029 Overflow: a=15, b=1, c=0 -> sum=0000, carry=1111; a=15, b=15, c=1 -> sum=1111, carry=1111.
REQ-030 Exhaustive: all 512 (a,b,c) combinations with in_valid=1 -> {carry[3],sum} equals a+b+c, per-stage carry matches reference model, each one cycle late.
